rpn_result_printer: RTL and testbench

Transmit-side counterpart of the RPN core's result output. Accepts the core's 16-bit result pulse (res_value/res_ready), converts it to signed or unsigned decimal ASCII, and streams the characters plus an end-of-line sequence to the UART transmitter over a valid/ready byte interface. Sits between the RPN core and the UART TX, mirroring the RX parser that feeds op/num into the core.

---
 rtl/rpn_pkg.sv | 24 ++
 rtl/rpn_bin2bcd.sv | 60 ++++++
 rtl/rpn_result_printer.sv | 171 +++++++++++++++++
 tb/tb_rpn_result_printer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN result printer: ASCII codes, widths and FSM states.
package rpn_pkg;

    localparam int BIN_W      = 16;
    localparam int BCD_DIGITS = 5;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_SIGN,
        ST_DIGIT,
        ST_EOL
    } state_e;

    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
        return ASCII_0 + {4'b0000, d};
    endfunction

endpackage

// File: rtl/rpn_bin2bcd.sv
// Sequential double-dabble: 16-bit binary to five BCD digits, done pulses 16 cycles after start.
module rpn_bin2bcd
    import rpn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [BIN_W-1:0]        bin_i,
    output logic [4*BCD_DIGITS-1:0] bcd_o,
    output logic                    done_o
);

    localparam int SR_W = 4*BCD_DIGITS + BIN_W;

    logic [SR_W-1:0] sr_q, sr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            done_q, done_d;

    function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] s);
        logic [SR_W-1:0] t;
        t = s;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (t[BIN_W+4*d +: 4] >= 4'd5) begin
                t[BIN_W+4*d +: 4] = t[BIN_W+4*d +: 4] + 4'd3;
            end
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    // The first iteration runs on the load edge, so 15 remain afterwards.
    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start_i) begin
            sr_d  = dd_step({{(4*BCD_DIGITS){1'b0}}, bin_i});
            cnt_d = 4'(BIN_W - 1);
        end else if (cnt_q != 4'd0) begin
            sr_d   = dd_step(sr_q);
            cnt_d  = cnt_q - 4'd1;
            done_d = (cnt_q == 4'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bcd_o  = sr_q[SR_W-1:BIN_W];
    assign done_o = done_q;

endmodule

// File: rtl/rpn_result_printer.sv
// Prints each RPN core result as decimal ASCII plus end-of-line over a valid/ready byte stream.
// state    | meaning
// IDLE     | waiting for a result or a pending value
// CONV     | double-dabble running on the magnitude
// SIGN     | presenting '-'
// DIGIT    | presenting digits, most significant first
// EOL      | presenting CR and/or LF
module rpn_result_printer #(
    parameter bit SIGNED   = 1'b1,
    parameter bit EOL_CRLF = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] res_value,
    input  logic        res_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        overrun
);
    import rpn_pkg::*;

    state_e                  state_q, state_d;
    logic [BIN_W-1:0]        val_q, val_d;
    logic [BIN_W-1:0]        pend_val_q, pend_val_d;
    logic                    pend_full_q, pend_full_d;
    logic                    start_q, start_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic [2:0]              idx_q, idx_d;
    logic                    overrun_q, overrun_d;

    logic                    neg;
    logic [BIN_W-1:0]        mag;
    logic [4*BCD_DIGITS-1:0] bcd;
    logic                    bcd_done;
    logic [2:0]              first_idx;
    logic                    accept;

    function automatic logic [3:0] digit_at(input logic [4*BCD_DIGITS-1:0] b,
                                            input logic [2:0] i);
        return b[{i, 2'b00} +: 4];
    endfunction

    assign neg    = SIGNED && val_q[BIN_W-1];
    assign mag    = neg ? (~val_q + 16'd1) : val_q;
    assign accept = tx_valid_q && tx_ready;

    rpn_bin2bcd u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_q),
        .bin_i   (mag),
        .bcd_o   (bcd),
        .done_o  (bcd_done)
    );

    // Highest nonzero digit; the units digit is always printed.
    always_comb begin
        first_idx = 3'd0;
        for (int k = 1; k < BCD_DIGITS; k++) begin
            if (digit_at(bcd, 3'(k)) != 4'd0) first_idx = 3'(k);
        end
    end

    always_comb begin
        state_d     = state_q;
        val_d       = val_q;
        pend_val_d  = pend_val_q;
        pend_full_d = pend_full_q;
        start_d     = 1'b0;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        idx_d       = idx_q;
        overrun_d   = 1'b0;

        if (res_ready && state_q != ST_IDLE) begin
            pend_val_d  = res_value;
            pend_full_d = 1'b1;
            overrun_d   = pend_full_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (res_ready) begin
                    val_d   = res_value;
                    state_d = ST_CONV;
                    start_d = 1'b1;
                end else if (pend_full_q) begin
                    val_d       = pend_val_q;
                    pend_full_d = 1'b0;
                    state_d     = ST_CONV;
                    start_d     = 1'b1;
                end
            end
            ST_CONV: begin
                if (bcd_done) begin
                    tx_valid_d = 1'b1;
                    idx_d      = first_idx;
                    if (neg) begin
                        state_d   = ST_SIGN;
                        tx_data_d = ASCII_MINUS;
                    end else begin
                        state_d   = ST_DIGIT;
                        tx_data_d = bcd_to_ascii(digit_at(bcd, first_idx));
                    end
                end
            end
            ST_SIGN: begin
                if (accept) begin
                    state_d   = ST_DIGIT;
                    tx_data_d = bcd_to_ascii(digit_at(bcd, idx_q));
                end
            end
            ST_DIGIT: begin
                if (accept) begin
                    if (idx_q == 3'd0) begin
                        state_d   = ST_EOL;
                        tx_data_d = EOL_CRLF ? ASCII_CR : ASCII_LF;
                    end else begin
                        idx_d     = idx_q - 3'd1;
                        tx_data_d = bcd_to_ascii(digit_at(bcd, idx_q - 3'd1));
                    end
                end
            end
            ST_EOL: begin
                if (accept) begin
                    if (EOL_CRLF && tx_data_q == ASCII_CR) begin
                        tx_data_d = ASCII_LF;
                    end else begin
                        state_d    = ST_IDLE;
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            val_q       <= '0;
            pend_val_q  <= '0;
            pend_full_q <= 1'b0;
            start_q     <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            idx_q       <= 3'd0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            val_q       <= val_d;
            pend_val_q  <= pend_val_d;
            pend_full_q <= pend_full_d;
            start_q     <= start_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            idx_q       <= idx_d;
            overrun_q   <= overrun_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = (state_q != ST_IDLE);
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_rpn_result_printer.sv
// Drives a signed/CRLF printer and an unsigned/LF printer side by side against a decimal reference model.
module tb_rpn_result_printer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] res_value;
    logic        res_ready;
    logic        tx_ready;
    logic [7:0]  tx_data_s, tx_data_u;
    logic        tx_valid_s, tx_valid_u;
    logic        busy_s, busy_u;
    logic        overrun_s, overrun_u;

    int n_tests = 0;
    int n_fail  = 0;
    bit rdy_rand = 1'b0;

    logic [7:0] got_s[$], got_u[$], exp_s[$], exp_u[$];
    int         ov_s = 0, ov_u = 0;
    bit         hold_s = 1'b0, hold_u = 1'b0;
    logic [7:0] hold_data_s, hold_data_u;

    always #5 clk = ~clk;

    rpn_result_printer #(.SIGNED(1'b1), .EOL_CRLF(1'b1)) dut_s (
        .clk(clk), .rst(rst), .res_value(res_value), .res_ready(res_ready),
        .tx_data(tx_data_s), .tx_valid(tx_valid_s), .tx_ready(tx_ready),
        .busy(busy_s), .overrun(overrun_s)
    );

    rpn_result_printer #(.SIGNED(1'b0), .EOL_CRLF(1'b0)) dut_u (
        .clk(clk), .rst(rst), .res_value(res_value), .res_ready(res_ready),
        .tx_data(tx_data_u), .tx_valid(tx_valid_u), .tx_ready(tx_ready),
        .busy(busy_u), .overrun(overrun_u)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Decimal text of v for both printer configurations.
    task automatic expect_line(input logic [15:0] v);
        for (int c = 0; c < 2; c++) begin
            logic [7:0] line[$];
            int mag;
            line.delete();
            mag = int'(v);
            if (c == 0 && v[15]) mag = 65536 - mag;
            do begin
                line.push_front(8'(32'h30 + mag % 10));
                mag = mag / 10;
            end while (mag > 0);
            if (c == 0 && v[15]) line.push_front(8'h2D);
            if (c == 0) line.push_back(8'h0D);
            line.push_back(8'h0A);
            foreach (line[i]) begin
                if (c == 0) exp_s.push_back(line[i]);
                else        exp_u.push_back(line[i]);
            end
        end
    endtask

    task automatic compare_lines();
        chk("len_s", 32'(got_s.size()), 32'(exp_s.size()));
        for (int i = 0; i < exp_s.size() && i < got_s.size(); i++)
            chk("byte_s", 32'(got_s[i]), 32'(exp_s[i]));
        chk("len_u", 32'(got_u.size()), 32'(exp_u.size()));
        for (int i = 0; i < exp_u.size() && i < got_u.size(); i++)
            chk("byte_u", 32'(got_u[i]), 32'(exp_u[i]));
        got_s.delete(); got_u.delete(); exp_s.delete(); exp_u.delete();
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse(input logic [15:0] v);
        res_value = v;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    // Both printers idle for several cycles (long enough for a pending value to restart).
    task automatic wait_quiet();
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < 3000) begin
            @(negedge clk);
            n++;
            if (!busy_s && !busy_u && !tx_valid_s && !tx_valid_u) quiet++;
            else quiet = 0;
        end
        chk("quiet_timeout", 32'(quiet), 32'd4);
        step();
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid_s && tx_ready) got_s.push_back(tx_data_s);
            if (tx_valid_u && tx_ready) got_u.push_back(tx_data_u);
            if (hold_s) begin
                chk("hold_valid_s", 32'(tx_valid_s), 32'd1);
                chk("hold_data_s", 32'(tx_data_s), 32'(hold_data_s));
            end
            if (hold_u) begin
                chk("hold_valid_u", 32'(tx_valid_u), 32'd1);
                chk("hold_data_u", 32'(tx_data_u), 32'(hold_data_u));
            end
            if (overrun_s) ov_s++;
            if (overrun_u) ov_u++;
        end
        hold_s      = !rst && tx_valid_s && !tx_ready;
        hold_u      = !rst && tx_valid_u && !tx_ready;
        hold_data_s = tx_data_s;
        hold_data_u = tx_data_u;
    end

    initial begin
        logic [15:0] corner[4];
        int lat;
        int ov0_s, ov0_u;
        logic [15:0] v1, v2;

        rst = 1'b1; res_ready = 1'b0; res_value = 16'h0; tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_s", 32'(tx_valid_s), 32'd0);
        chk("rst_data_s", 32'(tx_data_s), 32'h00);
        chk("rst_busy_s", 32'(busy_s), 32'd0);
        chk("rst_ovr_s", 32'(overrun_s), 32'd0);
        chk("rst_valid_u", 32'(tx_valid_u), 32'd0);
        chk("rst_busy_u", 32'(busy_u), 32'd0);
        step();
        rst = 1'b0;
        step();

        // 123: latency, back-to-back bytes, busy release
        pulse(16'd123);
        expect_line(16'd123);
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(negedge clk);
            if (tx_valid_s) lat = n;
        end
        chk("latency_s", 32'(lat), 32'd18);
        chk("latency_u", 32'(tx_valid_u), 32'd1);
        chk("first_byte", 32'(tx_data_s), 32'h31);
        repeat (4) @(negedge clk);
        chk("last_byte", 32'(tx_data_s), 32'h0A);
        chk("busy_last_byte", 32'(busy_s), 32'd1);
        chk("busy_u_done", 32'(busy_u), 32'd0);
        @(negedge clk);
        chk("busy_after_eol", 32'(busy_s), 32'd0);
        chk("valid_after_eol", 32'(tx_valid_s), 32'd0);
        wait_quiet();
        compare_lines();

        // Corner values; the last one under random back-pressure
        corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000; corner[3] = 16'd4096;
        for (int i = 0; i < 4; i++) begin
            rdy_rand = (i == 3);
            pulse(corner[i]);
            expect_line(corner[i]);
            wait_quiet();
            compare_lines();
        end

        // 7, 8, 9 on consecutive cycles: 8 is overwritten
        rdy_rand = 1'b0;
        step();
        ov0_s = ov_s; ov0_u = ov_u;
        res_value = 16'd7; res_ready = 1'b1; step();
        res_value = 16'd8; step();
        res_value = 16'd9; step();
        res_ready = 1'b0;
        expect_line(16'd7);
        expect_line(16'd9);
        wait_quiet();
        compare_lines();
        chk("overrun_cnt_s", 32'(ov_s - ov0_s), 32'd1);
        chk("overrun_cnt_u", 32'(ov_u - ov0_u), 32'd1);

        // Reset while the second digit of 555 is presented
        pulse(16'd555);
        repeat (18) step();
        chk("pre_rst_valid", 32'(tx_valid_s), 32'd1);
        chk("pre_rst_data", 32'(tx_data_s), 32'h35);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid_s", 32'(tx_valid_s), 32'd0);
        chk("post_rst_busy_s", 32'(busy_s), 32'd0);
        chk("post_rst_valid_u", 32'(tx_valid_u), 32'd0);
        chk("post_rst_busy_u", 32'(busy_u), 32'd0);
        exp_s.push_back(8'h35);
        exp_u.push_back(8'h35);
        compare_lines();
        step();
        pulse(16'd1);
        expect_line(16'd1);
        wait_quiet();
        compare_lines();

        // Random values, random back-pressure, sometimes a second result while busy
        rdy_rand = 1'b1;
        ov0_s = ov_s; ov0_u = ov_u;
        for (int i = 0; i < 25; i++) begin
            v1 = 16'($urandom);
            pulse(v1);
            expect_line(v1);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 10)) step();
                v2 = 16'($urandom);
                pulse(v2);
                expect_line(v2);
            end
            wait_quiet();
        end
        compare_lines();
        chk("no_overrun_s", 32'(ov_s - ov0_s), 32'd0);
        chk("no_overrun_u", 32'(ov_u - ov0_u), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
